versatile_fifo_sc_ctrl: RTL

VERSATILE_FIFO_SC_CTRL -- requirements
Module: versatile_fifo_sc_ctrl

---
 rtl/versatile_fifo_sc_ctrl.sv | 68 ++++++
 1 files changed

// File: rtl/versatile_fifo_sc_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM with a
// registered (1-cycle) read port. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate flag.
module versatile_fifo_sc_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned AFULL_LEVEL = 2**ADDR_WIDTH - 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic                  ram_we_a,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL = AFULL_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic [ADDR_WIDTH:0] rptr_next;
  logic                push;
  logic                pop;

  // Occupancy, handshakes and RAM port drive, all from registered pointers
  always_comb begin
    count       = wptr - rptr;
    almost_full = (count >= AFULL);
    wr_ready    = rst_n & ~flush & (count != DEPTH);
    push        = wr_valid & wr_ready;
    pop         = rd_valid & rd_ready;
    rptr_next   = rptr + {{ADDR_WIDTH{1'b0}}, pop};
    ram_we_a    = push;
    ram_adr_a   = wptr[ADDR_WIDTH-1:0];
    ram_d_a     = wr_data;
    // Reading at rptr_next lets the RAM register the following word on the
    // same edge as a pop, so back-to-back pops stream without a bubble.
    ram_adr_b   = rptr_next[ADDR_WIDTH-1:0];
    rd_data     = ram_q_b;
  end

  // Pointer and read-valid registers; reset and flush both empty the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      rptr <= rptr_next;
      // Uses wptr before this cycle's push: a word written now is not yet
      // readable through the registered RAM port until the next edge.
      rd_valid <= ((wptr - rptr_next) != '0);
    end
  end

endmodule
